// File: rtl/tx_skp_scheduler_pkg.sv
// Shared PHY TX definitions: 8b/10b ordered-set K-codes, scheduler state encoding
// and the registered output symbol bundle.
package tx_skp_scheduler_pkg;

    localparam logic [7:0] K28_5_COM = 8'hBC;
    localparam logic [7:0] K28_0_SKP = 8'h1C;
    localparam logic [7:0] IDLE_DATA = 8'h00;

    typedef enum logic [1:0] {
        ST_DATA = 2'd0,
        ST_COM  = 2'd1,
        ST_SKP  = 2'd2
    } skp_state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       k;
        logic       en;
        logic       active;
        logic       sent;
    } tx_sym_t;

    localparam tx_sym_t TX_IDLE = '0;

endpackage

// File: rtl/tx_skp_scheduler.sv
// Inserts COM + SKP_LEN x SKP ordered sets into the MAC symbol stream, either
// periodically (Skp_Interval DATA cycles) or on demand (Skp_Force). Latency 1.
module tx_skp_scheduler
    import tx_skp_scheduler_pkg::*;
#(
    parameter int SKP_LEN    = 3,
    parameter int INTERVAL_W = 12
) (
    input  logic                  PCLK,
    input  logic                  Reset_n,
    input  logic [7:0]            MAC_TX_Data,
    input  logic                  MAC_TX_DataK,
    input  logic                  MAC_Data_En,
    output logic                  MAC_Ready,
    input  logic                  Skp_Enable,
    input  logic [INTERVAL_W-1:0] Skp_Interval,
    input  logic                  Skp_Force,
    output logic [7:0]            TxData,
    output logic                  TxDataK,
    output logic                  TX_Data_En,
    output logic                  Skp_Active,
    output logic                  Skp_Sent
);

    localparam int              SCW      = 3;
    localparam logic [SCW-1:0]  SKP_LAST = SCW'(SKP_LEN - 1);

    skp_state_e            state, state_nxt;
    logic [SCW-1:0]        skp_cnt, skp_cnt_nxt;
    logic [INTERVAL_W-1:0] ivl_cnt, ivl_cnt_nxt;
    logic                  pending, pending_nxt;
    logic                  expiry, start_set;
    tx_sym_t               sym_nxt, sym_q;

    // Interval compared live; a shrunk interval below the count wraps the counter.
    assign expiry    = (state == ST_DATA) && Skp_Enable && (Skp_Interval != '0) &&
                       (ivl_cnt == Skp_Interval - INTERVAL_W'(1));
    assign start_set = expiry || ((state == ST_DATA) && pending);

    always_ff @(posedge PCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= ST_DATA;
            skp_cnt <= '0;
            ivl_cnt <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_nxt;
            skp_cnt <= skp_cnt_nxt;
            ivl_cnt <= ivl_cnt_nxt;
            pending <= pending_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        skp_cnt_nxt = skp_cnt;
        ivl_cnt_nxt = ivl_cnt;
        pending_nxt = pending | Skp_Force;
        case (state)
            ST_DATA: begin
                if (start_set) begin
                    // A force landing on the launch cycle merges into this set.
                    state_nxt   = ST_COM;
                    ivl_cnt_nxt = '0;
                    pending_nxt = 1'b0;
                end else begin
                    ivl_cnt_nxt = ivl_cnt + INTERVAL_W'(1);
                end
            end
            ST_COM: begin
                state_nxt   = ST_SKP;
                skp_cnt_nxt = '0;
                ivl_cnt_nxt = '0;
            end
            ST_SKP: begin
                ivl_cnt_nxt = '0;
                if (skp_cnt == SKP_LAST) begin
                    state_nxt   = ST_DATA;
                    skp_cnt_nxt = '0;
                end else begin
                    skp_cnt_nxt = skp_cnt + SCW'(1);
                end
            end
            default: begin
                state_nxt   = ST_DATA;
                skp_cnt_nxt = '0;
                ivl_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        sym_nxt = TX_IDLE;
        case (state)
            ST_DATA: begin
                if (MAC_Data_En) begin
                    sym_nxt.data = MAC_TX_Data;
                    sym_nxt.k    = MAC_TX_DataK;
                    sym_nxt.en   = 1'b1;
                end else begin
                    sym_nxt.data = IDLE_DATA;
                end
            end
            ST_COM: begin
                sym_nxt.data   = K28_5_COM;
                sym_nxt.k      = 1'b1;
                sym_nxt.en     = 1'b1;
                sym_nxt.active = 1'b1;
            end
            ST_SKP: begin
                sym_nxt.data   = K28_0_SKP;
                sym_nxt.k      = 1'b1;
                sym_nxt.en     = 1'b1;
                sym_nxt.active = 1'b1;
                sym_nxt.sent   = (skp_cnt == SKP_LAST);
            end
            default: sym_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge Reset_n) begin
        if (!Reset_n) sym_q <= TX_IDLE;
        else          sym_q <= sym_nxt;
    end

    assign MAC_Ready  = (state == ST_DATA);
    assign TxData     = sym_q.data;
    assign TxDataK    = sym_q.k;
    assign TX_Data_En = sym_q.en;
    assign Skp_Active = sym_q.active;
    assign Skp_Sent   = sym_q.sent;

endmodule

// File: tb/tb_tx_skp_scheduler.sv
// Directed scoreboard bench for tx_skp_scheduler: expected symbol streams are
// queued up front and a negedge monitor pops them as TX_Data_En presents symbols.
module tb_tx_skp_scheduler;

    localparam int SKP_LEN    = 3;
    localparam int INTERVAL_W = 12;

    logic                  PCLK = 1'b0;
    logic                  Reset_n = 1'b1;
    logic [7:0]            MAC_TX_Data = '0;
    logic                  MAC_TX_DataK = 1'b0;
    logic                  MAC_Data_En = 1'b0;
    logic                  MAC_Ready;
    logic                  Skp_Enable = 1'b0;
    logic [INTERVAL_W-1:0] Skp_Interval = '0;
    logic                  Skp_Force = 1'b0;
    logic [7:0]            TxData;
    logic                  TxDataK;
    logic                  TX_Data_En;
    logic                  Skp_Active;
    logic                  Skp_Sent;

    tx_skp_scheduler #(.SKP_LEN(SKP_LEN), .INTERVAL_W(INTERVAL_W)) dut (
        .PCLK(PCLK), .Reset_n(Reset_n),
        .MAC_TX_Data(MAC_TX_Data), .MAC_TX_DataK(MAC_TX_DataK),
        .MAC_Data_En(MAC_Data_En), .MAC_Ready(MAC_Ready),
        .Skp_Enable(Skp_Enable), .Skp_Interval(Skp_Interval), .Skp_Force(Skp_Force),
        .TxData(TxData), .TxDataK(TxDataK), .TX_Data_En(TX_Data_En),
        .Skp_Active(Skp_Active), .Skp_Sent(Skp_Sent)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic [7:0] d;
        logic       k;
        logic       act;
        logic       sent;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_sym(input logic [7:0] d, input logic k, input logic act, input logic sent);
        exp_t e;
        e.d = d; e.k = k; e.act = act; e.sent = sent;
        exp_q.push_back(e);
    endtask

    task automatic push_set();
        push_sym(8'hBC, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < SKP_LEN; i++) push_sym(8'h1C, 1'b1, 1'b1, i == SKP_LEN - 1);
    endtask

    task automatic tick();
        @(posedge PCLK); #1;
    endtask

    task automatic do_reset(input logic [INTERVAL_W-1:0] ivl, input logic en);
        tick();
        Reset_n = 1'b0; Skp_Interval = ivl; Skp_Enable = en;
        MAC_Data_En = 1'b0; Skp_Force = 1'b0; MAC_TX_Data = '0; MAC_TX_DataK = 1'b0;
        tick(); tick();
        Reset_n = 1'b1;
    endtask

    task automatic watch(input int n, output int low, output int sent);
        low = 0; sent = 0;
        repeat (n) begin
            @(negedge PCLK);
            if (!MAC_Ready) low++;
            if (Skp_Sent) sent++;
        end
    endtask

    // Monitor: every valid symbol must match the head of the expected queue;
    // idle cycles must present an all-zero symbol.
    always @(negedge PCLK) begin
        if (TX_Data_En) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_symbol: got data 0x%0h k %0b, expected no symbol (t=%0t)",
                         TxData, TxDataK, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("tx_symbol", {21'b0, TxData, TxDataK, Skp_Active, Skp_Sent}, {21'b0, mon_e});
            end
        end else begin
            check("idle_zero", {21'b0, TxData, TxDataK, Skp_Active, Skp_Sent}, 32'h0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int         acc, lowrun, guard, sets, gap, idle, low, sent;
    logic       rdy, seen;
    logic [7:0] d;

    initial begin
        // Reset state
        #1 Reset_n = 1'b0;
        #2;
        check("reset_outputs", {27'b0, TxData, TxDataK, TX_Data_En, Skp_Active, Skp_Sent}, 32'h0);
        check("reset_mac_ready", {31'b0, MAC_Ready}, 32'h1);

        // Interval 8, continuous MAC data: 8 data symbols then BC 1C 1C 1C, repeated
        do_reset(12'd8, 1'b1);
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 8; i++) push_sym(8'(s * 8 + i), (s * 8 + i) == 15, 1'b0, 1'b0);
            push_set();
        end
        d = 8'd0; MAC_TX_Data = d; MAC_TX_DataK = 1'b0; MAC_Data_En = 1'b1;
        acc = 0; lowrun = 0; guard = 0;
        while (acc < 24 && guard < 200) begin
            @(negedge PCLK);
            rdy = MAC_Ready;
            if (!rdy) lowrun++;
            else begin
                if (lowrun != 0) check("t1_ready_low_len", lowrun, 4);
                lowrun = 0;
            end
            tick();
            guard++;
            if (rdy) begin
                acc++; d = d + 8'd1;
                MAC_TX_Data = d; MAC_TX_DataK = (d == 8'd15);
            end
        end
        check("t1_accepted", acc, 24);
        MAC_Data_En = 1'b0;
        repeat (6) tick();
        Skp_Enable = 1'b0;
        repeat (4) tick();
        check("t1_queue_drained", exp_q.size(), 0);

        // Single force with periodic insertion off
        do_reset(12'd0, 1'b0);
        push_set();
        repeat (3) tick();
        Skp_Force = 1'b1;
        tick(); Skp_Force = 1'b0;
        @(negedge PCLK); check("t2_ready_n1", {31'b0, MAC_Ready}, 32'h1);
        @(negedge PCLK); check("t2_ready_n2", {31'b0, MAC_Ready}, 32'h0);
        watch(10, low, sent);
        check("t2_low_after", low, 3);
        check("t2_sent_pulses", sent, 1);
        check("t2_queue_drained", exp_q.size(), 0);

        // Force during SKP: second set after one DATA cycle
        do_reset(12'd0, 1'b0);
        push_set(); push_set();
        tick();
        Skp_Force = 1'b1;
        tick(); Skp_Force = 1'b0;
        tick(); tick(); tick();
        @(negedge PCLK); check("t3_in_skp", {31'b0, MAC_Ready}, 32'h0);
        Skp_Force = 1'b1;
        tick(); Skp_Force = 1'b0;
        tick();
        @(negedge PCLK); check("t3_data_gap", {31'b0, MAC_Ready}, 32'h1);
        @(negedge PCLK); check("t3_second_set", {31'b0, MAC_Ready}, 32'h0);
        watch(12, low, sent);
        check("t3_low_after", low, 3);
        check("t3_sent_pulses", sent, 1);
        check("t3_queue_drained", exp_q.size(), 0);

        // No MAC data, interval 4: four idle cycles between sets
        do_reset(12'd4, 1'b1);
        push_set(); push_set(); push_set();
        sets = 0; gap = 0; guard = 0;
        while (sets < 3 && guard < 100) begin
            @(negedge PCLK);
            guard++;
            if (!TX_Data_En) gap++;
            else if (TxData === 8'hBC) begin
                if (sets > 0) check("t4_idle_gap", gap, 4);
                gap = 0;
            end
            if (Skp_Sent) sets++;
        end
        check("t4_sets_seen", sets, 3);
        tick(); Skp_Enable = 1'b0;
        repeat (4) tick();
        check("t4_queue_drained", exp_q.size(), 0);

        // Reset while COM is on TxData, then interval restarts from zero
        do_reset(12'd6, 1'b1);
        push_sym(8'hBC, 1'b1, 1'b1, 1'b0);
        seen = 1'b0; guard = 0;
        while (!seen && guard < 40) begin
            @(negedge PCLK);
            guard++;
            if (TX_Data_En && TxData === 8'hBC) seen = 1'b1;
        end
        check("t5_com_seen", {31'b0, seen}, 32'h1);
        #2 Reset_n = 1'b0;
        #1;
        check("t5_async_outputs", {27'b0, TxData, TxDataK, TX_Data_En, Skp_Active, Skp_Sent}, 32'h0);
        check("t5_async_ready", {31'b0, MAC_Ready}, 32'h1);
        check("t5_abandoned", exp_q.size(), 0);
        tick(); Reset_n = 1'b1;
        push_set();
        @(negedge PCLK);
        seen = 1'b0; idle = 0; guard = 0;
        while (!seen && guard < 40) begin
            @(negedge PCLK);
            guard++;
            if (TX_Data_En) seen = 1'b1;
            else idle++;
        end
        check("t5_restart_gap", idle, 6);
        tick(); Skp_Enable = 1'b0;
        repeat (6) tick();
        check("t5_queue_drained", exp_q.size(), 0);

        // Interval lowered from 100 to 5 at count 50: counter must wrap first
        do_reset(12'd100, 1'b1);
        push_set();
        repeat (50) tick();
        Skp_Interval = 12'd5;
        seen = 1'b0; guard = 0;
        while (!seen && guard < 5000) begin
            @(negedge PCLK);
            if (TX_Data_En) seen = 1'b1;
            else guard++;
        end
        check("t6_wrap_delay", guard, 4052);
        tick(); Skp_Enable = 1'b0;
        repeat (6) tick();
        check("t6_queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
